dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Two-requester arbiter/sequencer in front of the 256x32 data memory of the single-cycle MIPS.
//  Port 0 = CPU load/store path; port 1 = program/data loader (UART/debug DMA).
//  Serialises accesses, drives the memory's memRead/memWrite/address/writeData, and returns
//  registered read data plus a one-cycle done pulse to the winning requester.
// PARAMETERS
//  FIXED_PRIO  0   0: round-robin between ports; 1: port 0 always wins ties
//  AW          8   memory index width; mem_addr[31:AW] driven 0, index = cmd address[AW-1:0]
// PORTS
//  clk         in   1   system clock, all state on posedge
//  rst_n       in   1   asynchronous, active-low reset
//  req0        in   1   port 0 request; held with we0/addr0/wdata0 stable until done0
//  we0         in   1   port 0: 1 = write, 0 = read
//  addr0       in   32  port 0 address
//  wdata0      in   32  port 0 write data
//  done0       out  1   port 0 one-cycle completion pulse
//  rdata0      out  32  port 0 read data, valid with done0, held until next port-0 read
//  req1/we1/addr1/wdata1/done1/rdata1        same as port 0, for port 1
//  mem_read    out  1   to DataMemory memRead
//  mem_write   out  1   to DataMemory memWrite
//  mem_addr    out  32  to DataMemory address
//  mem_wdata   out  32  to DataMemory writeData
//  mem_rdata   in   32  from DataMemory readData (combinational read)
//  busy        out  1   1 while a command is captured (state BUSY)
// BEHAVIOUR
//  Reset: state=IDLE, last_gnt=1 (port 0 wins first tie), cmd regs=0, done0/1=0, rdata0/1=0,
//   mem_read=mem_write=0, busy=0. Reset is async: asserting rst_n low mid-BUSY drops mem_write
//   immediately; no write commits on the following edge; the aborted access never signals done.
//  FSM (2 states):
//   IDLE: if req0|req1 -> capture winner's {port,we,addr[AW-1:0],wdata} into cmd regs, -> BUSY.
//   BUSY: mem_read=~cmd_we, mem_write=cmd_we, mem_addr={0,cmd_addr}, mem_wdata=cmd_wdata.
//     At the edge leaving BUSY: write commits in memory; on read, mem_rdata -> rdata[port];
//     done[port]<=1 for exactly one cycle; last_gnt<=port; -> IDLE (unconditional).
//  mem_read/mem_write/mem_addr/mem_wdata are decoded from state+cmd regs only (no input paths);
//   outside BUSY mem_read=mem_write=0, mem_addr/mem_wdata hold cmd values.
//  Latency: req sampled at edge N -> BUSY cycle N..N+1 -> done high in cycle after edge N+1.
//   Throughput one access per 2 cycles; the done cycle is an IDLE cycle, so arbitration for
//   the next command happens in parallel with done.
//  Requester must deassert req in its done cycle if it has no further access; a req still high
//   in the done cycle is treated as a new request (back-to-back).
//  Arbitration (only when both req high in IDLE): FIXED_PRIO=1 -> port 0; else the port != last_gnt.
//   Single requester always wins regardless of last_gnt.
//  Req dropped during BUSY: command still completes and done still pulses.
//  Write: rdata of that port unchanged. Address bits above AW ignored (wrap modulo 2^AW).
//  done0 and done1 are never high in the same cycle.
// STRUCTURE
//  Shared package dmem_pkg: state encoding (ST_IDLE, ST_BUSY), port index constants P_CPU=0,
//   P_LDR=1, DMEM_AW default 8. Arbitration decision as sub-module rr_pick2
//   (inputs req[1:0], last, fixed; output winner); remaining FSM/datapath flat in this block.
// TESTING (bench instantiates DataMemory behind this block)
//  1 Port0 write addr=0x10 data=0xDEADBEEF, then read addr=0x10 -> done0 2 cycles after req
//    sampled, rdata0=0xDEADBEEF, done1 never pulses.
//  2 req0 & req1 both held high, reads of 0x01/0x02 after reset, FIXED_PRIO=0 -> grant order
//    0,1,0,1 (done0/done1 alternate every 2 cycles), one memory access per 2 cycles.
//  3 Same stimulus, FIXED_PRIO=1 -> only done0 pulses while req0 high; port 1 served once req0 drops.
//  4 Port1 write addr=0x1FF data=0x12345678, port0 read 0xFF -> rdata0=0x12345678 (wrap at AW=8).
//  5 Port0 write 0x20=0xAAAA5555, pull rst_n low mid-BUSY before edge -> mem_write falls
//    immediately, read of 0x20 afterward returns previous contents, no done0, outputs at reset values.
//  6 Port1 read starts, req1 dropped during BUSY -> done1 still pulses with correct rdata1;
//    rdata0 unchanged throughout.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter slice.
//   state_e     : arbiter FSM states (idle / command in flight)
//   P_CPU/P_LDR : requester port indices (CPU load/store path, loader DMA)
//   DMEM_AW     : default memory index width (256-word data memory)
package dmem_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic P_CPU = 1'b0;
  localparam logic P_LDR = 1'b1;

  localparam int unsigned DMEM_AW = 8;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
//   reqN/weN/addrN/wdataN : requester N command, held stable until doneN
//   doneN/rdataN          : one-cycle completion pulse and registered read data
//   mem_*                 : DataMemory control/address/data (mem_rdata is combinational)
//   busy                  : a captured command is in flight
// modport slave  : arbiter view
// modport master : requesters + memory view
interface dmem_arbiter_if;

  logic        req0;
  logic        we0;
  logic [31:0] addr0;
  logic [31:0] wdata0;
  logic        done0;
  logic [31:0] rdata0;

  logic        req1;
  logic        we1;
  logic [31:0] addr1;
  logic [31:0] wdata1;
  logic        done1;
  logic [31:0] rdata1;

  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        busy;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_rdata,
    output done0, rdata0, done1, rdata1,
    output mem_read, mem_write, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_rdata,
    input  done0, rdata0, done1, rdata1,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    input  busy
  );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way arbitration decision.
//   req    : request vector, bit 0 = CPU port, bit 1 = loader port
//   last   : port that was granted most recently
//   fixed  : 1 = CPU port wins every tie, 0 = tie goes to the port that was not last
//   winner : selected port (only meaningful when req != 0)
module rr_pick2
  import dmem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed,
  output logic       winner
);

  always_comb begin
    winner = P_CPU;
    if (req == 2'b10) begin
      winner = P_LDR;
    end else if (req == 2'b11) begin
      winner = fixed ? P_CPU : ~last;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer in front of the single-cycle MIPS data memory.
// Each access takes one BUSY cycle; the following cycle carries the done pulse
// and is already an IDLE cycle, so a new command can be captured in parallel.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : requester commands/responses and DataMemory signals (slave modport)
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter bit          FIXED_PRIO = 1'b0,
  parameter int unsigned AW         = DMEM_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);

  state_e          state_q;
  logic            last_gnt_q;
  logic            cmd_port_q;
  logic            cmd_we_q;
  logic [AW-1:0]   cmd_addr_q;
  logic [31:0]     cmd_wdata_q;
  logic            done0_q;
  logic            done1_q;
  logic [31:0]     rdata0_q;
  logic [31:0]     rdata1_q;
  logic            winner;
  logic            unused_addr_hi;

  rr_pick2 u_pick (
    .req    ({bus.req1, bus.req0}),
    .last   (last_gnt_q),
    .fixed  (FIXED_PRIO),
    .winner (winner)
  );

  // Address bits above the memory index are don't-care (accesses wrap).
  assign unused_addr_hi = ^{bus.addr0[31:AW], bus.addr1[31:AW]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_gnt_q  <= P_LDR;
      cmd_port_q  <= P_CPU;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.req0 || bus.req1) begin
            cmd_port_q  <= winner;
            cmd_we_q    <= (winner == P_LDR) ? bus.we1            : bus.we0;
            cmd_addr_q  <= (winner == P_LDR) ? bus.addr1[AW-1:0]  : bus.addr0[AW-1:0];
            cmd_wdata_q <= (winner == P_LDR) ? bus.wdata1         : bus.wdata0;
            state_q     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Memory read is combinational, so the data is stable at this edge.
          if (!cmd_we_q) begin
            if (cmd_port_q == P_LDR) rdata1_q <= bus.mem_rdata;
            else                     rdata0_q <= bus.mem_rdata;
          end
          if (cmd_port_q == P_LDR) done1_q <= 1'b1;
          else                     done0_q <= 1'b1;
          last_gnt_q <= cmd_port_q;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Memory strobes come from registered state only, so an async reset drops
  // them immediately and nothing commits on the next edge.
  assign bus.mem_read  = (state_q == ST_BUSY) && !cmd_we_q;
  assign bus.mem_write = (state_q == ST_BUSY) &&  cmd_we_q;
  assign bus.mem_addr  = {{(32-AW){1'b0}}, cmd_addr_q};
  assign bus.mem_wdata = cmd_wdata_q;
  assign bus.busy      = (state_q == ST_BUSY);

  assign bus.done0  = done0_q;
  assign bus.done1  = done1_q;
  assign bus.rdata0 = rdata0_q;
  assign bus.rdata1 = rdata1_q;

endmodule
